// File: rtl/conv_buffer.sv
// conv_buffer: raster pixel stream to zero-padded NxN "same" convolution windows
module conv_buffer #(
  parameter int N          = 3,
  parameter int BitSize    = 4,
  parameter int ImageWidth = 4
) (
  input  logic                               clk,
  input  logic                               res_n,
  input  logic                               in_valid,
  input  logic [BitSize-1:0]                 in_data,
  output logic                               out_ready,
  output logic                               out_valid,
  output logic [N-1:0][N-1:0][BitSize-1:0]   out_data,
  output logic                               out_done
);
  localparam int H    = (N - 1) / 2;
  localparam int P    = ImageWidth * H + H;
  localparam int L    = ImageWidth * (N - 1) + N;
  localparam int NPIX = ImageWidth * ImageWidth;
  localparam int CW   = $clog2(ImageWidth);
  localparam int KW   = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(ImageWidth - 1);
  typedef enum logic {STREAM, DRAIN} state_e;
  state_e                            state_q, state_d;
  logic [L-1:0][BitSize-1:0]         buf_q, buf_d, shifted;
  logic [CW-1:0]                     col_q, col_d, row_q, row_d;
  logic [KW-1:0]                     cnt_q, cnt_d;
  logic [N-1:0][N-1:0][BitSize-1:0]  win, out_data_q, out_data_d;
  logic                              out_valid_q, out_valid_d, out_done_q, out_done_d;
  logic                              accept, emit, last_in, last_win;
  int                                pr, pc;
  assign out_ready = state_q == STREAM;
  assign out_valid = out_valid_q;
  assign out_done  = out_done_q;
  assign out_data  = out_data_q;
  // index 0 holds the newest pixel; drain shifts zeros behind the last real pixel
  assign accept  = in_valid && state_q == STREAM;
  assign shifted = {buf_q[L-2:0], accept ? in_data : BitSize'(0)};
  // select window taps from the post-shift buffer, masking rows/columns outside the image
  always_comb begin
    pr  = 0;
    pc  = 0;
    win = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        pr = int'(row_q) + r - H;
        pc = int'(col_q) + c - H;
        win[r][c] = (pr >= 0 && pr < ImageWidth && pc >= 0 && pc < ImageWidth)
                    ? shifted[(N-1-r)*ImageWidth + (N-1-c)] : '0;
      end
  end
  // stream/drain sequencing, centre counters and registered window output
  always_comb begin
    last_in     = cnt_q == KW'(NPIX - 1);
    last_win    = row_q == LAST && col_q == LAST;
    emit        = state_q == DRAIN || (accept && cnt_q >= KW'(P));
    state_d     = state_q;
    buf_d       = (accept || state_q == DRAIN) ? shifted : buf_q;
    cnt_d       = accept ? (last_in ? '0 : cnt_q + KW'(1)) : cnt_q;
    col_d       = emit ? (col_q == LAST ? '0 : col_q + CW'(1)) : col_q;
    row_d       = (emit && col_q == LAST) ? row_q + CW'(1) : row_q;
    out_valid_d = emit;
    out_done_d  = emit && last_win;
    out_data_d  = emit ? win : out_data_q;
    if (accept && last_in) state_d = DRAIN;
    if (state_q == DRAIN && last_win) begin
      state_d = STREAM;
      buf_d   = '0;
      col_d   = '0;
      row_d   = '0;
    end
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= STREAM;
      buf_q       <= '0;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_done_q  <= out_done_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_conv_buffer.sv
// tb_conv_buffer: randomized scoreboard bench for conv_buffer against an image-array window model
module tb_conv_buffer;
  localparam int N = 3, B = 4, W = 4, H = 1, P = W * H + H, NP = W * W;
  typedef logic [N-1:0][N-1:0][B-1:0] win_t;
  typedef struct {
    int   tag;
    int   ctr;
    int   img;
    win_t win;
    logic done;
  } exp_t;
  logic clk = 0, res_n = 0, in_valid = 0;
  logic [B-1:0] in_data = '0;
  logic out_ready, out_valid, out_done;
  win_t out_data;
  exp_t q[$];
  exp_t e;
  int cyc = 0, checks = 0, errors = 0, pulses = 0, expected_pulses = 0, img_id = 0, img0_pulses = 0;
  logic [B-1:0] img [NP];
  int plan [NP] = '{7, 2, 2, 15, 8, 8, 15, 7, 15, 2, 8, 8, 15, 8, 8, 8};
  int kat [4][10] = '{'{0, 0, 0, 0, 0, 7, 2, 0, 8, 8},
                      '{5, 7, 2, 2, 8, 8, 15, 15, 2, 8},
                      '{3, 0, 0, 0, 2, 15, 0, 15, 7, 0},
                      '{15, 8, 8, 0, 8, 8, 0, 0, 0, 0}};
  conv_buffer #(.N(N), .BitSize(B), .ImageWidth(W)) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_done(out_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, want);
    end
  endtask
  // window centred on ctr of the current image, zero outside the image
  function automatic win_t model(int ctr);
    win_t w;
    int rr, cc;
    w = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        rr = ctr / W + r - H;
        cc = ctr % W + c - H;
        if (rr >= 0 && rr < W && cc >= 0 && cc < W) w[r][c] = img[rr*W + cc];
      end
    return w;
  endfunction
  task automatic push(int ctr, int tag);
    q.push_back('{tag, ctr, img_id, model(ctr), logic'(ctr == NP - 1)});
    expected_pulses++;
  endtask
  // monitor: every cycle, out_valid must match whether a window is due now
  always @(negedge clk) begin
    automatic logic due = q.size() > 0 && q[0].tag == cyc;
    chk("out_valid", out_valid, due);
    if (out_valid) pulses++;
    if (due) begin
      e = q.pop_front();
      if (out_valid) begin
        chk($sformatf("window_c%0d", e.ctr), out_data, e.win);
        chk($sformatf("done_c%0d", e.ctr), out_done, e.done);
        if (e.img == 0) begin
          img0_pulses++;
          for (int i = 0; i < 4; i++)
            if (kat[i][0] == e.ctr) begin
              automatic win_t w = '0;
              for (int j = 0; j < 9; j++) w[j/3][j%3] = B'(kat[i][j+1]);
              chk($sformatf("known_c%0d", e.ctr), out_data, w);
            end
        end
      end
    end else chk("out_done_idle", out_done, 0);
  end
  task automatic do_reset();
    @(negedge clk);
    res_n = 0;
    in_valid = 0;
    @(posedge clk);
    #1;
    expected_pulses -= q.size();
    q.delete();
    @(negedge clk);
    chk("rst_ready", out_ready, 1);
    chk("rst_data", out_data, 0);
    res_n = 1;
  endtask
  task automatic send_image(int gap_pct, bit junk, bit known, int abort_at);
    int k = 0, guard = 0;
    img_id++;
    if (known) img_id = 0;
    for (int i = 0; i < NP; i++) img[i] = known ? B'(plan[i]) : B'($urandom_range(15));
    while (k < NP) begin
      @(negedge clk);
      chk("ready_stream", out_ready, 1);
      if (k == abort_at) begin
        in_valid = 0;
        return;
      end
      if (++guard > 2000) begin
        errors++;
        $display("FAIL stream_timeout pixel %0d", k);
        return;
      end
      in_valid = $urandom_range(99) >= gap_pct;
      in_data  = in_valid ? img[k] : B'($urandom);
      if (in_valid && out_ready) begin
        if (k >= P) push(k - P, cyc + 1);
        if (k == NP - 1) for (int j = 1; j <= P; j++) push(NP - 1 - P + j, cyc + 1 + j);
        k++;
      end
    end
    for (int j = 0; j < P; j++) begin
      @(negedge clk);
      chk("ready_drain", out_ready, 0);
      in_valid = junk ? 1'($urandom_range(1)) : 1'b0;
      in_data  = B'($urandom);
    end
  endtask
  initial begin
    do_reset();
    send_image(0, 0, 1, -1);
    send_image(30, 1, 0, -1);
    for (int i = 0; i < 3; i++) send_image(40, i[0], 0, -1);
    send_image(20, 0, 0, 9);
    do_reset();
    send_image(25, 1, 0, -1);
    @(negedge clk);
    in_valid = 0;
    chk("ready_final", out_ready, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("pulse_total", pulses, expected_pulses);
    chk("img0_pulses", img0_pulses, NP);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
